vga_scan_generator: RTL and testbench

// - Pixel-side initiator of the sprite pixel interface: generates VGA raster timing, drives
//   vga_x_pos/vga_y_pos into the sprite/floor/wall/tank pipeline, and captures the returned
//   24-bit RGB.
// - Delays sync/blank to match the pipeline's memory read latency, so pins are pixel-aligned.
// - Exports a vblank window that lets the processor-side sprite register writes avoid tearing.

---
 rtl/vga_scan_generator_if.sv | 8 +
 rtl/vga_scan_generator.sv | 99 +++++++++
 tb/tb_vga_scan_generator.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_generator_if.sv
// vga_scan_generator_if: raster position out to the sprite pipeline, RGB back from it
interface vga_scan_generator_if;
    logic [31:0] vga_x_pos;
    logic [31:0] vga_y_pos;
    logic [23:0] rgb;
    modport master (output vga_x_pos, vga_y_pos, input rgb);
    modport slave (input vga_x_pos, vga_y_pos, output rgb);
endinterface

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: VGA raster timing with sync/blank delayed to line up with the pipeline's RGB
module vga_scan_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 2
) (
    input  logic                        vga_clk_i,
    input  logic                        rst_ni,
    vga_scan_generator_if.master        pix_if,
    output logic [7:0]                  R_o,
    output logic [7:0]                  G_o,
    output logic [7:0]                  B_o,
    output logic                        hsync_o,
    output logic                        vsync_o,
    output logic                        blank_no,
    output logic                        sync_no,
    output logic                        frame_start_o,
    output logic                        vblank_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [23:0]   rgb_q;
    logic          hsync_q, vsync_q, blank_q, frame_start_q, vblank_q;
    // {active, hs, vs} straight from the counters, and after the latency-matching delay
    logic [2:0]    term, tap;
    always_comb begin
        h_d  = (h_q == H_MAX) ? '0 : h_q + 1'b1;
        v_d  = (h_q != H_MAX) ? v_q : (v_q == V_MAX) ? '0 : v_q + 1'b1;
        term = {h_q < H_ACT && v_q < V_ACT,
                h_q >= HS_BEG && h_q <= HS_END,
                v_q >= VS_BEG && v_q <= VS_END};
    end
    always_ff @(posedge vga_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q           <= '0;
            v_q           <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            rgb_q         <= tap[2] ? pix_if.rgb : '0;
            hsync_q       <= ~tap[1];
            vsync_q       <= ~tap[0];
            blank_q       <= tap[2];
            frame_start_q <= h_q == H_MAX && v_q == V_MAX;
            vblank_q      <= v_q >= V_ACT;
        end
    end
    generate
        if (PIPE_LAT > 0) begin : g_dly
            logic [PIPE_LAT-1:0][2:0] dly_q;
            always_ff @(posedge vga_clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    dly_q <= '0;
                end else begin
                    dly_q[0] <= term;
                    for (int i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign tap = dly_q[PIPE_LAT-1];
        end else begin : g_nodly
            assign tap = term;
        end
    endgenerate
    assign pix_if.vga_x_pos = 32'(h_q);
    assign pix_if.vga_y_pos = 32'(v_q);
    assign R_o              = rgb_q[23:16];
    assign G_o              = rgb_q[15:8];
    assign B_o              = rgb_q[7:0];
    assign hsync_o          = hsync_q;
    assign vsync_o          = vsync_q;
    assign blank_no         = blank_q;
    assign sync_no          = 1'b1;
    assign frame_start_o    = frame_start_q;
    assign vblank_o         = vblank_q;
endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator: default-timing instance plus two shrunken rasters (PIPE_LAT 0 and 3) against an arithmetic model
module tb_vga_scan_generator;
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        sn;
        logic        fs;
        logic        vb;
    } obs_t;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    vga_scan_generator_if if0();
    vga_scan_generator_if if1();
    vga_scan_generator_if if2();
    logic [2:0][7:0]  r, g, b;
    logic [2:0]       hs, vs, bn, sn, fs, vb;
    logic [2:0][31:0] xs, ys;
    assign xs[0] = if0.vga_x_pos;
    assign xs[1] = if1.vga_x_pos;
    assign xs[2] = if2.vga_x_pos;
    assign ys[0] = if0.vga_y_pos;
    assign ys[1] = if1.vga_y_pos;
    assign ys[2] = if2.vga_y_pos;
    vga_scan_generator #(.PIPE_LAT(2)) dut0 (
        .vga_clk_i(clk), .rst_ni(rst_n), .pix_if(if0.master),
        .R_o(r[0]), .G_o(g[0]), .B_o(b[0]), .hsync_o(hs[0]), .vsync_o(vs[0]),
        .blank_no(bn[0]), .sync_no(sn[0]), .frame_start_o(fs[0]), .vblank_o(vb[0]));
    vga_scan_generator #(.H_ACTIVE(40), .H_FP(6), .H_SYNC(8), .H_BP(10),
                         .V_ACTIVE(12), .V_FP(5), .V_SYNC(2), .V_BP(2), .PIPE_LAT(0)) dut1 (
        .vga_clk_i(clk), .rst_ni(rst_n), .pix_if(if1.master),
        .R_o(r[1]), .G_o(g[1]), .B_o(b[1]), .hsync_o(hs[1]), .vsync_o(vs[1]),
        .blank_no(bn[1]), .sync_no(sn[1]), .frame_start_o(fs[1]), .vblank_o(vb[1]));
    vga_scan_generator #(.H_ACTIVE(40), .H_FP(6), .H_SYNC(8), .H_BP(10),
                         .V_ACTIVE(12), .V_FP(5), .V_SYNC(2), .V_BP(2), .PIPE_LAT(3)) dut2 (
        .vga_clk_i(clk), .rst_ni(rst_n), .pix_if(if2.master),
        .R_o(r[2]), .G_o(g[2]), .B_o(b[2]), .hsync_o(hs[2]), .vsync_o(vs[2]),
        .blank_no(bn[2]), .sync_no(sn[2]), .frame_start_o(fs[2]), .vblank_o(vb[2]));
    int errors, checks, n;
    logic [23:0] salt [3];
    int f0a, f0b, r0a;
    logic prev_hs0;
    int fs1 [3], fs2 [3], vs_start [3], vs_len [3], vb_cnt [3];
    logic vs_done [3];
    obs_t px53;
    function automatic void prm(input int k, output int ha, output int hf, output int hw, output int hb,
                                output int va, output int vf, output int vw, output int vbp, output int l);
        if (k == 0) begin
            ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vbp = 33; l = 2;
        end else begin
            ha = 40; hf = 6; hw = 8; hb = 10; va = 12; vf = 5; vw = 2; vbp = 2; l = (k == 1) ? 0 : 3;
        end
    endfunction
    function automatic logic [23:0] pix(int k, int h, int v);
        return {8'(h) ^ salt[k][23:16], 8'(v) ^ salt[k][15:8], salt[k][7:0]};
    endfunction
    function automatic obs_t get_obs(int k);
        obs_t o;
        o = '{x: xs[k], y: ys[k], r: r[k], g: g[k], b: b[k], hs: hs[k], vs: vs[k],
              bn: bn[k], sn: sn[k], fs: fs[k], vb: vb[k]};
        return o;
    endfunction
    // Pins after n edges show the raster position the counters held PIPE_LAT+1 edges earlier
    function automatic obs_t model(int k, int cyc);
        int ha, hf, hw, hb, va, vf, vw, vbp, l, ht, vt, c, h, v;
        logic act, hsa, vsa;
        obs_t e;
        prm(k, ha, hf, hw, hb, va, vf, vw, vbp, l);
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vbp;
        e.x = 32'(cyc % ht);
        e.y = 32'((cyc / ht) % vt);
        c = cyc - l - 1;
        h = 0; v = 0; act = 1'b0; hsa = 1'b0; vsa = 1'b0;
        if (c >= 0) begin
            h = c % ht;
            v = (c / ht) % vt;
            act = h < ha && v < va;
            hsa = h >= ha + hf && h < ha + hf + hw;
            vsa = v >= va + vf && v < va + vf + vw;
        end
        {e.r, e.g, e.b} = act ? pix(k, h, v) : 24'h0;
        e.hs = !hsa;
        e.vs = !vsa;
        e.bn = act;
        e.sn = 1'b1;
        e.fs = cyc > 0 && cyc % (ht * vt) == 0;
        e.vb = cyc > 0 && ((cyc - 1) / ht) % vt >= va;
        return e;
    endfunction
    // Behaves as the sprite pipeline: colour for the position shown PIPE_LAT edges ago, white in blanking
    function automatic logic [23:0] drv(int k, int cyc);
        int ha, hf, hw, hb, va, vf, vw, vbp, l, ht, vt, m, h, v;
        prm(k, ha, hf, hw, hb, va, vf, vw, vbp, l);
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vbp;
        m = cyc - l;
        if (m < 0) return 24'($urandom);
        h = m % ht;
        v = (m / ht) % vt;
        return (h < ha && v < va) ? pix(k, h, v) : 24'hFFFFFF;
    endfunction
    task automatic drive_all(int cyc);
        if0.rgb = drv(0, cyc);
        if1.rgb = drv(1, cyc);
        if2.rgb = drv(2, cyc);
    endtask
    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask
    task automatic chk_obs(string tag, int k, int cyc);
        obs_t o, e;
        o = get_obs(k);
        e = model(k, cyc);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s k=%0d n=%0d got %h exp %h", tag, k, cyc, o, e);
        end
    endtask
    task automatic clear_meas();
        f0a = -1; f0b = -1; r0a = -1; prev_hs0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fs1[k] = -1; fs2[k] = -1; vs_start[k] = -1; vs_len[k] = 0; vb_cnt[k] = 0; vs_done[k] = 1'b0;
        end
    endtask
    task automatic step();
        obs_t o;
        @(posedge clk);
        n++;
        #1;
        drive_all(n);
        for (int k = 0; k < 3; k++) chk_obs("cyc", k, n);
        o = get_obs(0);
        if (prev_hs0 && !o.hs) begin
            if (f0a < 0) f0a = n;
            else if (f0b < 0) f0b = n;
        end
        if (!prev_hs0 && o.hs && r0a < 0) r0a = n;
        prev_hs0 = o.hs;
        if (n == 2408) px53 = o;
        for (int k = 1; k < 3; k++) begin
            o = get_obs(k);
            if (o.fs) begin
                if (fs1[k] < 0) fs1[k] = n;
                else if (fs2[k] < 0) fs2[k] = n;
            end
            if (!o.vs) begin
                if (vs_start[k] < 0) vs_start[k] = n;
                if (!vs_done[k]) vs_len[k]++;
            end else if (vs_start[k] >= 0) begin
                vs_done[k] = 1'b1;
            end
            if (n <= 1344 && o.vb) vb_cnt[k]++;
        end
    endtask
    initial begin
        errors = 0;
        checks = 0;
        n = 0;
        salt[0] = 24'h0000A5;
        salt[1] = 24'($urandom);
        salt[2] = 24'($urandom);
        rst_n = 1'b0;
        if0.rgb = 24'hFFFFFF;
        if1.rgb = 24'hFFFFFF;
        if2.rgb = 24'hFFFFFF;
        clear_meas();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_obs("reset", k, 0);
        drive_all(0);
        rst_n = 1'b1;
        repeat (1100) step();
        #2;
        rst_n = 1'b0;
        if0.rgb = 24'hFFFFFF;
        if1.rgb = 24'hFFFFFF;
        if2.rgb = 24'hFFFFFF;
        #1;
        for (int k = 0; k < 3; k++) chk_obs("async_rst", k, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_obs("rst_hold", k, 0);
        n = 0;
        clear_meas();
        drive_all(0);
        rst_n = 1'b1;
        repeat (2800) step();
        chk("hs_fall1", f0a, 659);
        chk("hs_rise1", r0a, 755);
        chk("hs_fall2", f0b, 1459);
        chk("px53_r", int'(px53.r), 8'h05);
        chk("px53_g", int'(px53.g), 8'h03);
        chk("px53_b", int'(px53.b), 8'hA5);
        chk("px53_blank_n", int'(px53.bn), 1);
        for (int k = 1; k < 3; k++) begin
            chk("fs_first", fs1[k], 1344);
            chk("fs_second", fs2[k], 2688);
            chk("vs_start", vs_start[k], (k == 1) ? 1089 : 1092);
            chk("vs_len", vs_len[k], 128);
            chk("vblank_cnt", vb_cnt[k], 576);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
